// File: rtl/freq_meter_pkg.sv
// Shared frequency-meter definitions: frame sequencer states and ASCII codes.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_SEND,
    ST_CR,
    ST_LF,
    ST_DONE
  } fsm_state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_QMARK = 8'd63;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;

endpackage

// File: rtl/ascii_frame_sequencer.sv
// Streams a latched BCD reading MSD-first as ASCII through the shared digit
// converter to the UART, with optional leading-zero suppression and CR LF.
module ascii_frame_sequencer
  import freq_meter_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SUPPRESS_LZ = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [3:0]              conv_digit,
  input  logic [7:0]              conv_ascii,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  fsm_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    seen_nz_q, seen_nz_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]              cur_digit;

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = shadow_q[4*i +: 4];
    end
  end

  // Invalid digits are masked so the converter never sees a non-BCD code.
  assign conv_digit = (cur_digit <= 4'd9) ? cur_digit : 4'd0;

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == ST_SEND) || (state_q == ST_CR) || (state_q == ST_LF);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seen_nz_d = seen_nz_q;
    tx_data_d = tx_data_q;
    shadow_d  = shadow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d  = bcd_in;
          idx_d     = IDX_W'(NUM_DIGITS - 1);
          seen_nz_d = 1'b0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((SUPPRESS_LZ != 0) && !seen_nz_q && (cur_digit == 4'd0) && (idx_q != '0)) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (cur_digit > 4'd9) begin
          // Converter holds its last output on invalid input, so bypass it.
          tx_data_d = ASCII_QMARK;
          seen_nz_d = 1'b1;
          state_d   = ST_SEND;
        end else begin
          seen_nz_d = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tx_data_d = conv_ascii;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == '0) begin
            tx_data_d = ASCII_CR;
            state_d   = ST_CR;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_CR: begin
        if (tx_ready) begin
          tx_data_d = ASCII_LF;
          state_d   = ST_LF;
        end
      end
      ST_LF: begin
        if (tx_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      seen_nz_q <= 1'b0;
      tx_data_q <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      seen_nz_q <= seen_nz_d;
      tx_data_q <= tx_data_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Directed bench for ascii_frame_sequencer with a registered digit-converter model.
module tb_ascii_frame_sequencer;
  import freq_meter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] bcd_in;
  logic [3:0]  conv_digit;
  logic [7:0]  conv_ascii;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  ascii_frame_sequencer #(.NUM_DIGITS(8), .SUPPRESS_LZ(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .bcd_in(bcd_in),
    .conv_digit(conv_digit), .conv_ascii(conv_ascii),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Registered converter: one cycle latency, holds output on invalid input.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) conv_ascii <= '0;
    else if (conv_digit <= 4'd9) conv_ascii <= ASCII_ZERO + {4'd0, conv_digit};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [31:0] bcd, input int stall, input bit glitch,
                           input int exp_done, input string tag);
    int cyc;
    int scnt;
    bit fin;
    bit holding;
    logic [7:0] held;
    got_q.delete();
    @(negedge CLK);
    bcd_in = bcd; start = 1'b1; tx_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; cyc = 1; scnt = 0; fin = 1'b0; holding = 1'b0; held = '0;
    while (!fin && cyc < 400) begin
      if (glitch && cyc == 5) begin start = 1'b1; bcd_in = ~bcd; end
      if (glitch && cyc == 6) start = 1'b0;
      if (holding) begin
        check_eq({tag, " hold_valid"}, {31'd0, tx_valid}, 32'd1);
        check_eq({tag, " hold_data"}, {24'd0, tx_data}, {24'd0, held});
      end
      if (done) begin
        check_eq({tag, " done_cycle"}, cyc, exp_done);
        fin = 1'b1;
      end else if (tx_valid) begin
        if (scnt < stall) begin
          tx_ready = 1'b0; scnt++; holding = 1'b1; held = tx_data;
        end else begin
          tx_ready = 1'b1; got_q.push_back(tx_data); scnt = 0; holding = 1'b0;
        end
      end else begin
        tx_ready = 1'b1;
        holding = 1'b0;
      end
      if (!fin) begin
        @(negedge CLK);
        cyc++;
      end
    end
    if (!fin) check_eq({tag, " timeout"}, 32'd0, 32'd1);
    check_eq({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq({tag, $sformatf(" byte%0d", i)}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    if (glitch) begin
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    repeat (10) @(negedge CLK);
    check_eq({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " idle_valid"}, {31'd0, tx_valid}, 32'd0);
    bcd_in = '0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; bcd_in = '0; tx_ready = 1'b1;
    #12;
    check_eq("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst done", {31'd0, done}, 32'd0);
    check_eq("rst tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst conv_digit", {28'd0, conv_digit}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    exp_q = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd13, 8'd10};
    run_frame(32'h1234_5678, 0, 1'b0, 27, "full");

    exp_q = '{8'd52, 8'd50, 8'd13, 8'd10};
    run_frame(32'h0000_0042, 0, 1'b0, 15, "lz42");

    exp_q = '{8'd48, 8'd13, 8'd10};
    run_frame(32'h0000_0000, 0, 1'b0, 13, "zero");

    exp_q = '{8'd55, 8'd13, 8'd10};
    run_frame(32'h0000_0007, 0, 1'b0, 13, "seven");
    run_frame(32'h0000_0007, 5, 1'b0, 28, "stall7");

    exp_q = '{8'd63, 8'd53, 8'd63, 8'd48, 8'd13, 8'd10};
    run_frame(32'h0000_A5B0, 0, 1'b0, 17, "invalid");

    exp_q = '{8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd13, 8'd10};
    run_frame(32'h1234_5678, 0, 1'b1, 27, "glitch");

    // Reset while a character is being offered and stalled.
    @(negedge CLK);
    bcd_in = 32'h1234_5678; start = 1'b1; tx_ready = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge CLK);
    check_eq("mid valid", {31'd0, tx_valid}, 32'd1);
    check_eq("mid data", {24'd0, tx_data}, 32'd49);
    #2 RST = 1'b1;
    #1;
    check_eq("arst tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("arst busy", {31'd0, busy}, 32'd0);
    check_eq("arst done", {31'd0, done}, 32'd0);
    check_eq("arst tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("arst conv_digit", {28'd0, conv_digit}, 32'd0);
    @(negedge CLK);
    RST = 1'b0; tx_ready = 1'b1;

    exp_q = '{8'd52, 8'd50, 8'd13, 8'd10};
    run_frame(32'h0000_0042, 0, 1'b0, 15, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
